// File: rtl/intc_wb8_pkg.sv
// Shared definitions for the 8-bit Wishbone interrupt controller: register offsets,
// CLAIM layout and a small one-hot helper.
package intc_wb8_pkg;

    localparam logic [2:0] INTC_REG_PENDING = 3'd0;
    localparam logic [2:0] INTC_REG_ENABLE  = 3'd1;
    localparam logic [2:0] INTC_REG_EDGE    = 3'd2;
    localparam logic [2:0] INTC_REG_ACTIVE  = 3'd3;
    localparam logic [2:0] INTC_REG_CLAIM   = 3'd4;
    localparam logic [2:0] INTC_REG_SOFTSET = 3'd5;
    localparam logic [2:0] INTC_REG_CTRL    = 3'd6;

    localparam int INTC_CLAIM_VALID_BIT = 7;

    function automatic logic [7:0] intc_onehot(input logic [2:0] idx);
        intc_onehot = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first 8->3 priority encoder with an any-request flag.
module intc_prio_enc (
    input  logic [7:0] req_i,
    output logic [2:0] idx_o,
    output logic       any_o
);

    // Scan from the top down so the lowest set index is the last one assigned
    always_comb begin
        idx_o = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx_o = req_i[i] ? 3'(i) : idx_o;
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/intc_wb8.sv
// Interrupt controller on the 8-bit Wishbone I/O bus: latches peripheral interrupt lines as
// pending, applies enable / edge-level mode and drives the single CPU interrupt input.
module intc_wb8
    import intc_wb8_pkg::*;
#(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [2:0]             ADR_I,
    input  logic [7:0]             DAT_I,
    input  logic                   STB_I,
    input  logic                   WE_I,
    output logic [7:0]             DAT_O,
    output logic                   ACK_O,
    input  logic [NUM_SOURCES-1:0] I_irq,
    output logic                   O_interrupt
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SOURCES) - 9'd1);

    logic [7:0] pend_q, pend_d;
    logic [7:0] en_q, en_d;
    logic [7:0] edge_q, edge_d;
    logic [7:0] irq_prev_q, irq_prev_d;
    logic       gie_q, gie_d;
    logic       ack_q, ack_d;
    logic [7:0] dat_q, dat_d;
    logic       int_q, int_d;

    logic [7:0] irq_s, active_s, claim_s, rdata_s;
    logic [7:0] w1c_s, claim_clr_s, swset_s, edge_pend_s;
    logic [2:0] claim_idx_s;
    logic       claim_any_s, commit_s, wr_s, rd_s;

    assign active_s = pend_q & en_q;

    intc_prio_enc u_prio (
        .req_i (active_s),
        .idx_o (claim_idx_s),
        .any_o (claim_any_s)
    );

    // Bus decode, pending update and next-state of every register
    always_comb begin
        irq_s = 8'h00;
        irq_s[NUM_SOURCES-1:0] = I_irq;

        commit_s = STB_I & ~ack_q;
        wr_s     = commit_s & WE_I;
        rd_s     = commit_s & ~WE_I;

        claim_s = 8'h00;
        claim_s[INTC_CLAIM_VALID_BIT] = claim_any_s;
        claim_s[2:0] = claim_idx_s;

        // Read data is taken from the state before this edge's side effects
        case (ADR_I)
            INTC_REG_PENDING: rdata_s = pend_q;
            INTC_REG_ENABLE:  rdata_s = en_q;
            INTC_REG_EDGE:    rdata_s = edge_q;
            INTC_REG_ACTIVE:  rdata_s = active_s;
            INTC_REG_CLAIM:   rdata_s = claim_s;
            INTC_REG_CTRL:    rdata_s = {7'b0000000, gie_q};
            default:          rdata_s = 8'h00;
        endcase

        w1c_s       = (wr_s && ADR_I == INTC_REG_PENDING) ? DAT_I : 8'h00;
        swset_s     = (wr_s && ADR_I == INTC_REG_SOFTSET) ? DAT_I : 8'h00;
        claim_clr_s = (rd_s && ADR_I == INTC_REG_CLAIM && claim_any_s) ?
                      intc_onehot(claim_idx_s) : 8'h00;

        // New edges and software sets are OR-ed in after the clear, so a racing event survives
        edge_pend_s = (pend_q & ~(w1c_s | claim_clr_s)) | (irq_s & ~irq_prev_q) | swset_s;
        pend_d      = ((edge_q & edge_pend_s) | (~edge_q & irq_s)) & SRC_MASK;

        en_d   = (wr_s && ADR_I == INTC_REG_ENABLE) ? (DAT_I & SRC_MASK) : en_q;
        edge_d = (wr_s && ADR_I == INTC_REG_EDGE)   ? (DAT_I & SRC_MASK) : edge_q;
        gie_d  = (wr_s && ADR_I == INTC_REG_CTRL)   ? DAT_I[0] : gie_q;

        irq_prev_d = irq_s;
        ack_d      = commit_s;
        dat_d      = rd_s ? rdata_s : 8'h00;
        int_d      = gie_q & (|active_s);
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pend_q     <= 8'h00;
            en_q       <= 8'h00;
            edge_q     <= 8'h00;
            irq_prev_q <= 8'h00;
            gie_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 8'h00;
            int_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            en_q       <= en_d;
            edge_q     <= edge_d;
            irq_prev_q <= irq_prev_d;
            gie_q      <= gie_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            int_q      <= int_d;
        end
    end

    assign DAT_O       = dat_q;
    assign ACK_O       = ack_q;
    assign O_interrupt = int_q;

endmodule
